// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the shared SRAM and the arbiter.
// The arbiter takes the slave modport; the requesters/SRAM side takes master.
interface mem_port_arbiter_if #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 16
);
    logic              M0_REQ;
    logic [AWIDTH-1:0] M0_ADDR;
    logic              M0_GNT;
    logic              M0_RVALID;
    logic [DWIDTH-1:0] M0_RDATA;

    logic              M1_REQ;
    logic              M1_WE;
    logic [AWIDTH-1:0] M1_ADDR;
    logic [3:0]        M1_BE;
    logic [DWIDTH-1:0] M1_WDATA;
    logic              M1_GNT;
    logic              M1_RVALID;
    logic [DWIDTH-1:0] M1_RDATA;

    logic              MEM_CSN;
    logic              MEM_WEN;
    logic [3:0]        MEM_BE;
    logic [AWIDTH-1:0] MEM_ADDR;
    logic [DWIDTH-1:0] MEM_DI;
    logic [DWIDTH-1:0] MEM_DOUT;

    logic [CWIDTH-1:0] GNT_CNT0;
    logic [CWIDTH-1:0] GNT_CNT1;
    logic [CWIDTH-1:0] STALL_CNT;

    modport slave (
        input  M0_REQ, M0_ADDR, M1_REQ, M1_WE, M1_ADDR, M1_BE, M1_WDATA, MEM_DOUT,
        output M0_GNT, M0_RVALID, M0_RDATA, M1_GNT, M1_RVALID, M1_RDATA,
        output MEM_CSN, MEM_WEN, MEM_BE, MEM_ADDR, MEM_DI,
        output GNT_CNT0, GNT_CNT1, STALL_CNT
    );

    modport master (
        output M0_REQ, M0_ADDR, M1_REQ, M1_WE, M1_ADDR, M1_BE, M1_WDATA, MEM_DOUT,
        input  M0_GNT, M0_RVALID, M0_RDATA, M1_GNT, M1_RVALID, M1_RDATA,
        input  MEM_CSN, MEM_WEN, MEM_BE, MEM_ADDR, MEM_DI,
        input  GNT_CNT0, GNT_CNT1, STALL_CNT
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between fetch (port 0) and
// data (port 1). Grants are combinational; read data returns one cycle later.
module mem_port_arbiter #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 16
) (
    input logic               CLK,
    input logic               RST,
    mem_port_arbiter_if.slave bus
);
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
    localparam logic [CWIDTH-1:0] CNT_MAX = '1;

    logic              pri;
    logic              rtag_valid;
    logic              rtag_port;
    logic              gnt0;
    logic              gnt1;
    logic              conflict;
    logic              rd_grant;
    logic [CWIDTH-1:0] gnt_cnt0;
    logic [CWIDTH-1:0] gnt_cnt1;
    logic [CWIDTH-1:0] stall_cnt;

    // Requests are masked while RST is high so nothing reaches the SRAM.
    always_comb begin
        conflict = !RST && bus.M0_REQ && bus.M1_REQ;
        gnt0     = !RST && bus.M0_REQ && (!bus.M1_REQ || pri == PORT0);
        gnt1     = !RST && bus.M1_REQ && (!bus.M0_REQ || pri == PORT1);
        rd_grant = gnt0 || (gnt1 && !bus.M1_WE);
    end

    always_comb begin
        bus.MEM_CSN  = 1'b1;
        bus.MEM_WEN  = 1'b1;
        bus.MEM_BE   = 4'b0000;
        bus.MEM_ADDR = '0;
        bus.MEM_DI   = '0;
        if (gnt0) begin
            bus.MEM_CSN  = 1'b0;
            bus.MEM_ADDR = bus.M0_ADDR;
        end else if (gnt1) begin
            bus.MEM_CSN  = 1'b0;
            bus.MEM_ADDR = bus.M1_ADDR;
            if (bus.M1_WE) begin
                bus.MEM_WEN = 1'b0;
                bus.MEM_BE  = bus.M1_BE;
                bus.MEM_DI  = bus.M1_WDATA;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pri        <= PORT1;
            rtag_valid <= 1'b0;
            rtag_port  <= PORT0;
            gnt_cnt0   <= '0;
            gnt_cnt1   <= '0;
            stall_cnt  <= '0;
        end else begin
            if (gnt0) begin
                pri <= PORT1;
            end else if (gnt1) begin
                pri <= PORT0;
            end
            rtag_valid <= rd_grant;
            rtag_port  <= gnt1;
            if (gnt0 && gnt_cnt0 != CNT_MAX) begin
                gnt_cnt0 <= gnt_cnt0 + 1'b1;
            end
            if (gnt1 && gnt_cnt1 != CNT_MAX) begin
                gnt_cnt1 <= gnt_cnt1 + 1'b1;
            end
            if (conflict && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign bus.M0_GNT    = gnt0;
    assign bus.M1_GNT    = gnt1;
    assign bus.M0_RVALID = rtag_valid && (rtag_port == PORT0);
    assign bus.M1_RVALID = rtag_valid && (rtag_port == PORT1);
    assign bus.M0_RDATA  = bus.MEM_DOUT;
    assign bus.M1_RDATA  = bus.MEM_DOUT;
    assign bus.GNT_CNT0  = gnt_cnt0;
    assign bus.GNT_CNT1  = gnt_cnt1;
    assign bus.STALL_CNT = stall_cnt;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one single-port synchronous SRAM (SP_SRAM-style: active-low CSN/WEN, byte enables, 1-cycle read latency) between two requesters. Port 0 is the instruction-fetch port (read-only); port 1 is the data load/store port. It sits between RISCV_TOP and a unified memory in single-memory builds, and also counts grants and conflict stalls for CPI debug.

## Interface
Parameters:
- AWIDTH, 12, SRAM word/byte address width passed through unchanged
- DWIDTH, 32, data width
- CWIDTH, 16, width of statistics counters

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- M0_REQ  in  1  fetch request, held until granted
- M0_ADDR  in  AWIDTH  fetch address
- M0_GNT  out  1  fetch request accepted this cycle
- M0_RVALID  out  1  M0_RDATA valid
- M0_RDATA  out  DWIDTH  fetch read data
- M1_REQ  in  1  data request, held until granted
- M1_WE  in  1  1 = write, 0 = read
- M1_ADDR  in  AWIDTH  data address
- M1_BE  in  4  byte enables for writes
- M1_WDATA  in  DWIDTH  write data
- M1_GNT  out  1  data request accepted this cycle
- M1_RVALID  out  1  M1_RDATA valid (reads only)
- M1_RDATA  out  DWIDTH  data read data
- MEM_CSN  out  1  SRAM chip select, active low
- MEM_WEN  out  1  SRAM write enable, active low
- MEM_BE  out  4  SRAM byte enables
- MEM_ADDR  out  AWIDTH  SRAM address
- MEM_DI  out  DWIDTH  SRAM write data
- MEM_DOUT  in  DWIDTH  SRAM read data, valid cycle after read access
- GNT_CNT0, GNT_CNT1  out  CWIDTH  grants issued per port
- STALL_CNT  out  CWIDTH  cycles where both requested (one lost)

## Operation
- State: priority pointer PRI (0 or 1), response tag register RTAG {valid, port}, three counters.
- Arbitration (combinational from REQ and PRI): only one REQ high -> that port granted; both high -> port PRI granted; none -> no grant.
- Exactly one of M0_GNT/M1_GNT high at most; GNT implies access issued to SRAM that same cycle.
- PRI update on grant: PRI <= other port than the one granted. No grant -> PRI holds. Reset PRI = 1 (data port wins first conflict).
- SRAM drive on grant to port 0: CSN=0, WEN=1, BE=4'b0000, ADDR=M0_ADDR, DI=0.
- Grant to port 1 read: CSN=0, WEN=1, BE=4'b0000, ADDR=M1_ADDR. Write: CSN=0, WEN=0, BE=M1_BE, ADDR=M1_ADDR, DI=M1_WDATA.
- No grant: CSN=1, WEN=1, BE=0, ADDR=0, DI=0.
- Read grant sets RTAG <= {1, port}; write or no grant sets RTAG.valid <= 0. Writes produce no RVALID.
- Response: Mx_RVALID = RTAG.valid && RTAG.port==x; both RDATA outputs = MEM_DOUT (qualify with RVALID).
- Counters: GNT_CNTx += 1 per grant to x; STALL_CNT += 1 each cycle M0_REQ && M1_REQ. All saturate at all-ones, never wrap.
- Request changes without grant are legal; arbiter is memoryless about ungranted requests.

## Timing
- Grant latency: 0 cycles (same cycle as REQ when won). Read data latency: 1 cycle after grant.
- Back-to-back grants every cycle allowed; pipelined reads give RVALID every cycle, alternating ports under sustained conflict.
- Max wait under conflict: 1 cycle (round-robin fairness).
- Reset (async, any time): PRI=1, RTAG.valid=0, counters=0; outputs immediately CSN=1, WEN=1, GNT=0, RVALID=0. A read granted the cycle before reset asserts never returns RVALID.
- During RST high, REQ inputs ignored; first grant possible in the first cycle RST is low.

## Test plan
- Reset: assert RST mid-read (M0 granted previous cycle) -> M0_RVALID=0, MEM_CSN=1, counters 0, PRI=1.
- Single port read: M0_REQ, ADDR=0x004, mem[1]=0x00500093 -> M0_GNT same cycle, next cycle M0_RVALID=1, M0_RDATA=0x00500093, M1_RVALID=0.
- Write then read: M1 write ADDR=0x010 BE=4'hF WDATA=0xDEADBEEF -> MEM_WEN=0, no RVALID; then M1 read 0x010 -> M1_RDATA=0xDEADBEEF one cycle later.
- Conflict: both REQ held 4 cycles after reset -> grant order 1,0,1,0; STALL_CNT=4; GNT_CNT0=2, GNT_CNT1=2.
- Byte write: mem[0x020]=0x11223344, M1 write BE=4'b0001 WDATA=0x000000AA -> readback 0x112233AA.
- Saturation: CWIDTH=4, hold M0_REQ 20 cycles -> GNT_CNT0 stops at 0xF.
